// File: rtl/dht11_scheduler.sv
// dht11_scheduler
//   Sequences the DHT11 single-wire reader. It issues periodic or on-demand read
//   starts, keeps the minimum gap the sensor needs between reads, retries failed
//   reads, and holds the last good humidity/temperature for downstream logic.
//
//   Build option: define DHT11_RANGE_CHECK_EN to reject implausible readings
//   (humidity > 95 or temperature > 50) as failed reads. When the macro is not
//   defined, every rd_done with rd_err=0 is accepted unchanged.
module dht11_scheduler #(
  parameter int unsigned PERIOD_CYC = 200_000_000,
  parameter int unsigned GAP_CYC    = 100_000_000,
  parameter int unsigned WDOG_CYC   = 5_000_000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       enable,
  input  logic       req,
  output logic       rd_start,
  input  logic       rd_busy,
  input  logic       rd_done,
  input  logic       rd_err,
  input  logic [7:0] rd_humidity,
  input  logic [7:0] rd_temperature,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       valid,
  output logic       update,
  output logic       sensor_fault,
  output logic [7:0] fail_cnt
);

  // The watchdog and gap counts are never live at the same time, so they share
  // one down-counter sized for the larger of the two.
  localparam int unsigned TMR_MAX = (GAP_CYC > WDOG_CYC) ? GAP_CYC : WDOG_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned PER_W   = $clog2(PERIOD_CYC + 1);
  localparam int unsigned RTRY_W  = $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0]  WDOG_LOAD  = TMR_W'(WDOG_CYC - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(GAP_CYC - 1);
  localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(PERIOD_CYC - 1);
  localparam logic [RTRY_W-1:0] RTRY_LAST  = RTRY_W'(MAX_RETRY - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic              pend_q, pend_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic [7:0]        hum_q, hum_d;
  logic [7:0]        temp_q, temp_d;
  logic              valid_q, valid_d;
  logic              update_q, update_d;
  logic              fault_q, fault_d;
  logic [7:0]        fail_q, fail_d;
  logic              start_q, start_d;

  logic in_range;
  logic read_ok;
  logic period_tick;
  logic fail_evt;

`ifdef DHT11_RANGE_CHECK_EN
  // Readings outside the DHT11's rated range are treated like a bad checksum.
  assign in_range = (rd_humidity <= 8'd95) && (rd_temperature <= 8'd50);
`else
  assign in_range = 1'b1;
`endif

  assign read_ok     = rd_done && !rd_err && in_range;
  assign period_tick = enable && (per_q == PER_LAST);
  // A read fails on a rejected rd_done, or on watchdog expiry when no rd_done
  // arrives in that same cycle (rd_done wins a tie).
  assign fail_evt    = (state_q == ST_WAIT) &&
                       ((rd_done && !read_ok) || (!rd_done && (tmr_q == '0)));

  // Next-state logic: period timer, pending flag, read sequencer and result hold.
  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through the
    // case statement can leave a latch behind.
    state_d  = state_q;
    per_d    = per_q;
    pend_d   = pend_q | req | period_tick;
    tmr_d    = tmr_q;
    retry_d  = retry_q;
    hum_d    = hum_q;
    temp_d   = temp_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    fail_d   = fail_q;
    start_d  = 1'b0;
    update_d = 1'b0;

    if (!enable || period_tick) begin
      per_d = '0;
    end else begin
      per_d = per_q + PER_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_START;
          // A request arriving in the consuming cycle is kept for later.
          pend_d  = req | period_tick;
        end
      end
      ST_START: begin
        if (!rd_busy) begin
          start_d = 1'b1;
          tmr_d   = WDOG_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_done || (tmr_q == '0)) begin
          tmr_d   = GAP_LOAD;
          state_d = ST_GAP;
          if (read_ok) begin
            hum_d    = rd_humidity;
            temp_d   = rd_temperature;
            update_d = 1'b1;
            valid_d  = 1'b1;
            retry_d  = '0;
            fault_d  = 1'b0;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin  // ST_GAP
        if (tmr_q == '0) begin
          if ((retry_q != '0) && enable) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
            retry_d = '0;  // a retry left pending when enable dropped is cancelled
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
    endcase

    if (fail_evt) begin
      if (fail_q != 8'hFF) begin
        fail_d = fail_q + 8'd1;
      end
      if (retry_q == RTRY_LAST) begin
        fault_d = 1'b1;
        retry_d = '0;
      end else begin
        retry_d = retry_q + RTRY_W'(1);
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= ST_IDLE;
      per_q    <= '0;
      pend_q   <= 1'b0;
      tmr_q    <= '0;
      retry_q  <= '0;
      hum_q    <= '0;
      temp_q   <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      fault_q  <= 1'b0;
      fail_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      tmr_q    <= tmr_d;
      retry_q  <= retry_d;
      hum_q    <= hum_d;
      temp_q   <= temp_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      fault_q  <= fault_d;
      fail_q   <= fail_d;
      start_q  <= start_d;
    end
  end

  assign rd_start     = start_q;
  assign humidity     = hum_q;
  assign temperature  = temp_q;
  assign valid        = valid_q;
  assign update       = update_q;
  assign sensor_fault = fault_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_dht11_scheduler.sv
// tb_dht11_scheduler
//   Drives dht11_scheduler with a behavioural DHT11 reader and compares its
//   outputs against a read-outcome model kept in the bench.
module tb_dht11_scheduler;

  localparam int PERIOD_CYC = 1000;
  localparam int GAP_CYC    = 100;
  localparam int WDOG_CYC   = 200;
  localparam int MAX_RETRY  = 3;

  localparam int K_OK  = 0;
  localparam int K_ERR = 1;
  localparam int K_TMO = 2;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       enable = 1'b0;
  logic       req = 1'b0;
  logic       rd_start;
  logic       rd_busy = 1'b0;
  logic       rd_done = 1'b0;
  logic       rd_err = 1'b0;
  logic [7:0] rd_humidity = 8'd0;
  logic [7:0] rd_temperature = 8'd0;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       valid;
  logic       update;
  logic       sensor_fault;
  logic [7:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model of the held results.
  int m_hum, m_temp, m_valid, m_fault, m_fail, m_consec;

  dht11_scheduler #(
    .PERIOD_CYC(PERIOD_CYC),
    .GAP_CYC   (GAP_CYC),
    .WDOG_CYC  (WDOG_CYC),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .enable        (enable),
    .req           (req),
    .rd_start      (rd_start),
    .rd_busy       (rd_busy),
    .rd_done       (rd_done),
    .rd_err        (rd_err),
    .rd_humidity   (rd_humidity),
    .rd_temperature(rd_temperature),
    .humidity      (humidity),
    .temperature   (temperature),
    .valid         (valid),
    .update        (update),
    .sensor_fault  (sensor_fault),
    .fail_cnt      (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_hum = 0; m_temp = 0; m_valid = 0; m_fault = 0; m_fail = 0; m_consec = 0;
  endtask

  // One completed attempt: success reloads the results, failure counts towards
  // the consecutive-failure limit and the saturating total.
  task automatic model_apply(input int ok, input int h, input int t);
    if (ok != 0) begin
      m_hum = h; m_temp = t; m_valid = 1; m_fault = 0; m_consec = 0;
    end else begin
      m_fail   = (m_fail < 255) ? m_fail + 1 : 255;
      m_consec = m_consec + 1;
      if (m_consec >= MAX_RETRY) begin
        m_fault  = 1;
        m_consec = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".humidity"},     int'(humidity),     m_hum);
    check({tag, ".temperature"},  int'(temperature),  m_temp);
    check({tag, ".valid"},        int'(valid),        m_valid);
    check({tag, ".sensor_fault"}, int'(sensor_fault), m_fault);
    check({tag, ".fail_cnt"},     int'(fail_cnt),     m_fail);
  endtask

  // Waits for rd_start; n is the number of ticks taken. Ends the test if the
  // bound expires.
  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (rd_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (rd_start !== 1'b1) begin
      check("rd_start_timeout", 0, 1);
      finish_test();
    end
  endtask

  // Plays the reader for one transaction, starting in the cycle rd_start is
  // seen. n_req extra req pulses are issued while the read is in flight.
  task automatic serve(input int kind, input int h, input int t, input int n_req);
    int lat;
    int k;
    int f0;
    f0 = int'(fail_cnt);
    rd_busy = 1'b1;
    if (kind == K_TMO) begin
      k = 0;
      while (int'(fail_cnt) == f0 && k < 2 * WDOG_CYC) begin
        tick();
        k++;
        if (k == 30) rd_busy = 1'b0;
      end
      check("wdog_latency", k, WDOG_CYC);
    end else begin
      lat = $urandom_range(60, 8);
      for (int j = 0; j < lat; j++) begin
        req = (j < 2 * n_req) && (j % 2 == 0);
        tick();
      end
      req = 1'b0;
      rd_done        = 1'b1;
      rd_err         = (kind == K_ERR);
      rd_humidity    = 8'(h);
      rd_temperature = 8'(t);
      rd_busy        = 1'b0;
      tick();
      rd_done        = 1'b0;
      rd_err         = 1'b0;
      rd_humidity    = 8'($urandom);
      rd_temperature = 8'($urandom);
    end
    rd_busy = 1'b0;
    model_apply(int'(kind == K_OK), h, t);
    check("update_on_result", int'(update), int'(kind == K_OK));
    check_outputs("after_read");
    tick();
    check("update_one_cycle", int'(update), 0);
  endtask

  initial begin
    int n;
    int cnt;
    int start_cyc;
    int retry_exp;
    int kind;
    int h;
    int t;
    int script_kind [8];
    script_kind = '{K_OK, K_ERR, K_ERR, K_ERR, K_OK, K_TMO, K_TMO, K_OK};
    model_reset();

    // Reset state.
    repeat (3) tick();
    check("reset.rd_start", int'(rd_start), 0);
    check("reset.update",   int'(update),   0);
    check_outputs("reset");
    reset_p = 1'b0;
    tick();

    // On-demand read with enable=0: rd_start two cycles after req.
    req = 1'b1;
    tick();
    req = 1'b0;
    check("req_lat_0", int'(rd_start), 0);
    tick();
    check("req_lat_1", int'(rd_start), 0);
    tick();
    check("req_lat_2", int'(rd_start), 1);
    serve(K_OK, $urandom_range(95, 0), $urandom_range(50, 0), 3);

    // Three requests during the read coalesce into exactly one more read.
    wait_start(GAP_CYC + 20, n);
    check("coalesced_start", n + 1, GAP_CYC + 2);
    serve(K_OK, $urandom_range(95, 0), $urandom_range(50, 0), 0);
    cnt = 0;
    repeat (1500) begin
      tick();
      cnt += int'(rd_start);
    end
    check("no_extra_read", cnt, 0);

    // Reader busy: stay in START without a pulse until it frees up.
    rd_busy = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    cnt = 0;
    repeat (50) begin
      tick();
      cnt += int'(rd_start);
    end
    check("no_start_while_busy", cnt, 0);
    rd_busy = 1'b0;
    tick();
    check("start_after_busy", int'(rd_start), 1);
    serve(K_ERR, $urandom_range(95, 0), $urandom_range(50, 0), 0);

    // Reset in WAIT returns everything to zero and idles.
    repeat (GAP_CYC + 5) tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_start(10, n);
    rd_busy = 1'b1;
    repeat (5) tick();
    reset_p = 1'b1;
    tick();
    model_reset();
    check("wait_reset.rd_start", int'(rd_start), 0);
    check("wait_reset.update",   int'(update),   0);
    check_outputs("wait_reset");
    reset_p = 1'b0;
    rd_busy = 1'b0;
    cnt = 0;
    repeat (50) begin
      tick();
      cnt += int'(rd_start);
    end
    check("idle_after_reset", cnt, 0);

    // Periodic reads: scripted outcomes first, then random ones.
    enable    = 1'b1;
    retry_exp = 0;
    start_cyc = cyc;
    for (int i = 0; i < 20; i++) begin
      wait_start(PERIOD_CYC + GAP_CYC + 300, n);
      if (i == 0) begin
        check("first_periodic", int'(n >= PERIOD_CYC && n <= PERIOD_CYC + 4), 1);
      end else if (retry_exp != 0) begin
        check("retry_spacing", n + 1, GAP_CYC + 1);
      end else begin
        check("gap_respected", int'(n + 1 >= GAP_CYC + 2), 1);
      end
      if (i == 1) check("period_spacing", cyc - start_cyc, PERIOD_CYC);
      start_cyc = cyc;
      if (i < 8) begin
        kind = script_kind[i];
      end else begin
        cnt  = $urandom_range(99, 0);
        kind = (cnt < 50) ? K_OK : ((cnt < 85) ? K_ERR : K_TMO);
      end
      h = (i == 0) ? 80 : $urandom_range(95, 0);
      t = (i == 0) ? 25 : $urandom_range(50, 0);
      serve(kind, h, t, 0);
      retry_exp = int'(m_consec != 0);
    end

    finish_test();
  end

endmodule
